// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and EX/MEM, MEM/WB operand forwarding.
// Outputs drive the EX-stage ALU directly; all controls are qualified by ex_valid.
module id_ex_stage #(
  parameter int N    = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic [REGW-1:0] id_rd,
  input  logic [N-1:0]    id_rs_data,
  input  logic [N-1:0]    id_rt_data,
  input  logic [N-1:0]    id_imm,
  input  logic [4:0]      id_shamt,
  input  logic [3:0]      id_alu_sel,
  input  logic            id_alu_src,
  input  logic            id_uses_rt,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            mem_reg_write,
  input  logic [REGW-1:0] mem_rd,
  input  logic [N-1:0]    mem_result,
  input  logic            wb_reg_write,
  input  logic [REGW-1:0] wb_rd,
  input  logic [N-1:0]    wb_result,
  output logic            hazard_stall,
  output logic            ex_valid,
  output logic [N-1:0]    ex_A,
  output logic [N-1:0]    ex_B,
  output logic [4:0]      ex_shamt,
  output logic [3:0]      ex_sel,
  output logic [N-1:0]    ex_store_data,
  output logic [REGW-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write
);

  logic            valid_reg;
  logic [REGW-1:0] rs_reg, rt_reg, rd_reg;
  logic [N-1:0]    rs_data_reg, rt_data_reg, imm_reg;
  logic [4:0]      shamt_reg;
  logic [3:0]      sel_reg;
  logic            alu_src_reg, reg_write_reg, mem_read_reg, mem_write_reg;
  logic            bubble;

  // A bubble clears every field, so data outputs also read 0 while EX is empty.
  assign bubble = rst | flush | (~stall & hazard_stall);

  always_ff @(posedge clk) begin
    if (bubble) begin
      valid_reg     <= 1'b0;
      rs_reg        <= '0;
      rt_reg        <= '0;
      rd_reg        <= '0;
      rs_data_reg   <= '0;
      rt_data_reg   <= '0;
      imm_reg       <= '0;
      shamt_reg     <= '0;
      sel_reg       <= '0;
      alu_src_reg   <= 1'b0;
      reg_write_reg <= 1'b0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
    end else if (!stall) begin
      valid_reg     <= id_valid;
      rs_reg        <= id_rs;
      rt_reg        <= id_rt;
      rd_reg        <= id_rd;
      rs_data_reg   <= id_rs_data;
      rt_data_reg   <= id_rt_data;
      imm_reg       <= id_imm;
      shamt_reg     <= id_shamt;
      sel_reg       <= id_alu_sel;
      alu_src_reg   <= id_alu_src;
      reg_write_reg <= id_reg_write;
      mem_read_reg  <= id_mem_read;
      mem_write_reg <= id_mem_write;
    end
  end

  assign ex_valid     = valid_reg;
  assign ex_reg_write = valid_reg & reg_write_reg;
  assign ex_mem_read  = valid_reg & mem_read_reg;
  assign ex_mem_write = valid_reg & mem_write_reg;
  assign ex_rd        = rd_reg;
  assign ex_shamt     = shamt_reg;
  assign ex_sel       = sel_reg;

  assign hazard_stall = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
                        ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

  // Index 0 = rs, index 1 = rt; the younger EX/MEM result wins over MEM/WB.
  logic [REGW-1:0] src_idx [2];
  logic [N-1:0]    src_data [2];
  logic [N-1:0]    fwd [2];

  assign src_idx[0]  = rs_reg;
  assign src_idx[1]  = rt_reg;
  assign src_data[0] = rs_data_reg;
  assign src_data[1] = rt_data_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    always_comb begin
      fwd[gi] = src_data[gi];
      if (src_idx[gi] != '0 && mem_reg_write && mem_rd == src_idx[gi])
        fwd[gi] = mem_result;
      else if (src_idx[gi] != '0 && wb_reg_write && wb_rd == src_idx[gi])
        fwd[gi] = wb_result;
    end
  end

  assign ex_A          = fwd[0];
  assign ex_B          = alu_src_reg ? imm_reg : fwd[1];
  assign ex_store_data = fwd[1];

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: pass-through, forwarding, load-use bubble, stall/flush and reset.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt;
  logic [3:0]  id_alu_sel;
  logic        id_alu_src, id_uses_rt, id_reg_write, id_mem_read, id_mem_write;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic        hazard_stall, ex_valid;
  logic [31:0] ex_A, ex_B, ex_store_data;
  logic [4:0]  ex_shamt, ex_rd;
  logic [3:0]  ex_sel;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.N(32), .REGW(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_alu_sel(id_alu_sel), .id_alu_src(id_alu_src),
    .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B),
    .ex_shamt(ex_shamt), .ex_sel(ex_sel), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [31:0] imm, input logic [4:0] sh, input logic [3:0] sel,
                        input logic src, input logic urt, input logic rw, input logic mr,
                        input logic mw);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_shamt = sh;
    id_alu_sel = sel; id_alu_src = src; id_uses_rt = urt;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  initial begin
    // 1. reset with random ID inputs
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    mem_reg_write = 1'b0; mem_rd = '0; mem_result = '0;
    wb_reg_write = 1'b0; wb_rd = '0; wb_result = '0;
    set_id(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom,
           $urandom, 5'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));
    tick(); tick();
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_sel", 32'(ex_sel), 32'd0);
    check("rst_reg_write", 32'(ex_reg_write), 32'd0);
    check("rst_rd", 32'(ex_rd), 32'd0);
    check("rst_hazard", 32'(hazard_stall), 32'd0);

    // 2. plain pass-through
    rst = 1'b0;
    set_id(1, 5'd1, 5'd2, 5'd3, 32'd59, 32'd77, 32'd456, 5'd5, 4'b0000, 0, 1, 1, 0, 0);
    tick();
    check("pass_A", ex_A, 32'd59);
    check("pass_B_rt", ex_B, 32'd77);
    check("pass_valid", 32'(ex_valid), 32'd1);
    check("pass_rw", 32'(ex_reg_write), 32'd1);
    check("pass_shamt", 32'(ex_shamt), 32'd5);
    check("pass_rd", 32'(ex_rd), 32'd3);
    id_alu_src = 1'b1; id_alu_sel = 4'b0011;
    tick();
    check("pass_B_imm", ex_B, 32'd456);
    check("pass_store", ex_store_data, 32'd77);
    check("pass_sel", 32'(ex_sel), 32'd3);

    // 3. forwarding
    set_id(1, 5'd8, 5'd4, 5'd6, 32'd100, 32'd200, 32'd0, 5'd0, 4'd2, 0, 1, 1, 0, 0);
    tick();
    mem_reg_write = 1'b1; mem_rd = 5'd8; mem_result = 32'h0000FFAA;
    wb_reg_write = 1'b1; wb_rd = 5'd8; wb_result = 32'd1;
    #1 check("fwd_mem_wins", ex_A, 32'h0000FFAA);
    check("fwd_rt_none", ex_B, 32'd200);
    mem_reg_write = 1'b0;
    #1 check("fwd_wb", ex_A, 32'd1);
    wb_rd = 5'd4;
    #1 check("fwd_wb_rt", ex_B, 32'd1);
    check("fwd_store_rt", ex_store_data, 32'd1);
    check("fwd_rs_regfile", ex_A, 32'd100);
    mem_reg_write = 1'b0; wb_reg_write = 1'b0;
    set_id(1, 5'd0, 5'd0, 5'd6, 32'd123, 32'd321, 32'd0, 5'd0, 4'd2, 0, 1, 1, 0, 0);
    tick();
    mem_reg_write = 1'b1; mem_rd = 5'd0; mem_result = 32'hDEAD0000;
    wb_reg_write = 1'b1; wb_rd = 5'd0; wb_result = 32'hBEEF0000;
    #1 check("fwd_r0_A", ex_A, 32'd123);
    check("fwd_r0_B", ex_B, 32'd321);
    mem_reg_write = 1'b0; wb_reg_write = 1'b0; mem_rd = '0; wb_rd = '0;

    // 4. load-use via rs
    set_id(1, 5'd1, 5'd9, 5'd9, 32'd0, 32'd0, 32'd4, 5'd0, 4'd2, 1, 0, 1, 1, 0);
    tick();
    check("lw_mem_read", 32'(ex_mem_read), 32'd1);
    set_id(1, 5'd9, 5'd2, 5'd10, 32'd7, 32'd8, 32'd0, 5'd0, 4'd2, 0, 1, 1, 0, 0);
    #1 check("lu_hazard", 32'(hazard_stall), 32'd1);
    tick();
    check("lu_bubble_valid", 32'(ex_valid), 32'd0);
    check("lu_bubble_rw", 32'(ex_reg_write), 32'd0);
    check("lu_hazard_clear", 32'(hazard_stall), 32'd0);
    tick();
    check("lu_add_valid", 32'(ex_valid), 32'd1);
    check("lu_add_rd", 32'(ex_rd), 32'd10);

    // load-use via rt depends on id_uses_rt
    set_id(1, 5'd1, 5'd9, 5'd9, 32'd0, 32'd0, 32'd4, 5'd0, 4'd2, 1, 0, 1, 1, 0);
    tick();
    set_id(1, 5'd2, 5'd9, 5'd11, 32'd7, 32'd8, 32'd0, 5'd0, 4'd2, 0, 1, 1, 0, 0);
    #1 check("lu_rt_hazard", 32'(hazard_stall), 32'd1);
    id_uses_rt = 1'b0;
    #1 check("lu_rt_unused", 32'(hazard_stall), 32'd0);
    tick();
    check("lu_rt_noBubble", 32'(ex_valid), 32'd1);
    check("lu_rt_rd", 32'(ex_rd), 32'd11);

    // 5. stall holds, flush beats stall
    set_id(1, 5'd3, 5'd4, 5'd5, 32'd11, 32'd22, 32'd0, 5'd1, 4'd7, 0, 1, 1, 0, 1);
    tick();
    stall = 1'b1;
    set_id(1, 5'd12, 5'd13, 5'd14, 32'd99, 32'd98, 32'd0, 5'd2, 4'd1, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall_rd_%0d", i), 32'(ex_rd), 32'd5);
      check($sformatf("stall_A_%0d", i), ex_A, 32'd11);
      check($sformatf("stall_mw_%0d", i), 32'(ex_mem_write), 32'd1);
    end
    flush = 1'b1;
    tick();
    check("flush_valid", 32'(ex_valid), 32'd0);
    check("flush_mw", 32'(ex_mem_write), 32'd0);
    flush = 1'b0; stall = 1'b0;

    // 6. reset while a load-use hazard is pending
    set_id(1, 5'd1, 5'd9, 5'd9, 32'd0, 32'd0, 32'd4, 5'd0, 4'd2, 1, 0, 1, 1, 0);
    tick();
    set_id(1, 5'd9, 5'd2, 5'd10, 32'd7, 32'd8, 32'd0, 5'd0, 4'd2, 0, 1, 1, 0, 0);
    #1 check("mid_hazard", 32'(hazard_stall), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 32'(ex_valid), 32'd0);
    check("mid_rst_mr", 32'(ex_mem_read), 32'd0);
    check("mid_rst_hazard", 32'(hazard_stall), 32'd0);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
